delay_line_flow_ctrl: RTL and testbench
=======================================

Name: delay_line_flow_ctrl

Overview:
- Flow-control controller for a DELAY-stage clock-enabled pixel delay line, giving it a valid/ready handshake on both sides.
- Tracks which stages hold valid beats and drives the shared `ce` of the `delay_line` it instantiates.
- Collapses bubbles, stalls on backpressure and provides a flush sequence for end-of-frame drain.
- Sits between a pixel source and a downstream filter stage in the video pipeline.

Parameters:
- N, 9, data width in bits (pixel word).
- DELAY, 2, number of pipeline stages; legal range 1..16.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous reset, active-high
- en  in  1  global enable; 0 freezes the block
- in_valid  in  1  source has a beat on idata
- in_ready  out  1  block accepts the beat this cycle
- idata  in  N  input pixel word
- out_valid  out  1  odata holds a valid beat
- out_ready  in  1  sink accepts the beat this cycle
- odata  out  N  output pixel word
- flush  in  1  single-cycle request to drain the pipeline
- flush_done  out  1  one-cycle pulse when the drain has completed
- busy  out  1  pipeline non-empty or flush in progress
- occupancy  out  $clog2(DELAY+1)  number of valid beats in flight

Behaviour:
- Clock and reset: one clock `clk`; reset `rst` is synchronous and active-high.
- Valid tracking:
  - Valid bits v[1..DELAY] are held locally with reset; they are not stored in `delay_line`.
  - v[DELAY] is the output stage.
- Stage enable: ce = en && (!v[DELAY] || out_ready).
  - All stages advance together, matching the single `ce` of `delay_line`.
- Handshake signals:
  - in_ready = ce && (state == RUN).
  - out_valid = v[DELAY].
  - odata = delay_line output.
- Transfers:
  - in_fire = in_valid && in_ready.
  - out_fire = out_valid && out_ready && en.
- Valid shift: when ce=1, v shifts by one stage with v[1] <= in_fire. When ce=0, v holds.
- Latency: a beat accepted in cycle t appears with out_valid=1 in cycle t+DELAY, given no stall.
- Bubble collapse: when out_valid=0, ce=1 regardless of out_ready, so empty slots are squeezed out.
- Stall: when out_valid=1 and out_ready=0, ce=0. odata stays stable and in_ready=0.
- Occupancy: occupancy <= occupancy + in_fire - out_fire.
  - It never exceeds DELAY and never underflows.
  - busy = (occupancy != 0) || (state != RUN).
- State machine: RUN, FLUSH, DONE.
  - RUN: flush=1 moves to FLUSH. A beat accepted in the same cycle as flush belongs to the drain.
  - FLUSH: in_ready=0 and ce follows the normal rule, so bubbles shift in. When occupancy==0, move to DONE.
  - DONE: flush_done=1 for exactly one cycle, then return to RUN.
  - flush is ignored in FLUSH and DONE.
- en=0:
  - ce, in_ready and out_fire are 0; v and occupancy hold.
  - State holds, except FLUSH may still move to DONE if occupancy==0.
- Reset, including mid-operation:
  - v=0, occupancy=0, state=RUN.
  - out_valid=0, flush_done=0, busy=0, in_ready=en.
  - Data registers are not reset; their contents are don't-care while out_valid=0.

Decomposition:
- Shared include file: state encodings RUN=2'd0, FLUSH=2'd1, DONE=2'd2, and the width function for occupancy.
- Sub-module: existing `delay_line` (parameters N, DELAY), driven with `ce`, carrying idata to odata.
- The valid-bit shift register and FSM stay local because they need reset.

Test Plan (N=9, DELAY=2):
- Stream: after rst, send 0x001, 0x002, 0x003 in t0..t2 with out_ready=1 -> out_valid in t2..t4 with 0x001, 0x002, 0x003; occupancy 1, 2, 2, 1, 0.
- Backpressure: fill to occupancy=2, then out_ready=0 for 5 cycles -> ce=0, in_ready=0, odata held at the head beat. After release, all beats emerge in order with none lost or duplicated.
- Bubble collapse: single beat 0x0AA, out_ready=0 throughout -> appears at t+2 with out_valid=1 and stays. Then ce=0; a second beat is accepted only once out_ready=1.
- Flush with traffic: occupancy=2, flush pulse in cycle f -> in_ready=0 from f+1, both beats drain, flush_done=1 for one cycle after occupancy reaches 0, then in_ready=1.
- Flush when empty: flush at cycle f -> FLUSH at f+1, flush_done=1 in cycle f+2 only, busy=1 in f+1..f+2.
- Reset and enable: rst during occupancy=2 -> next cycle out_valid=0, occupancy=0, state RUN. en=0 with beats in flight -> nothing moves; restoring en resumes with no loss.

Source files
------------

// File: rtl/delay_line_flow_ctrl_pkg.sv
// delay_line_flow_ctrl_pkg: shared state encoding and occupancy width helper
package delay_line_flow_ctrl_pkg;
  typedef enum logic [1:0] {
    RUN   = 2'd0,
    FLUSH = 2'd1,
    DONE  = 2'd2
  } state_t;
  function automatic int occ_w(input int depth);
    return $clog2(depth + 1);
  endfunction
endpackage

// File: rtl/delay_line_flow_ctrl_delay_line.sv
// delay_line: clock-enabled DELAY-stage data shift register without reset
module delay_line #(
  parameter int N     = 9,
  parameter int DELAY = 2
) (
  input  logic         clk,
  input  logic         ce,
  input  logic [N-1:0] idata,
  output logic [N-1:0] odata
);
  logic [DELAY*N-1:0] sr_q, sr_d;
  always_comb begin
    sr_d  = ce ? (DELAY*N)'({sr_q, idata}) : sr_q;
    odata = sr_q[DELAY*N-1 -: N];
  end
  always_ff @(posedge clk) begin
    sr_q <= sr_d;
  end
endmodule

// File: rtl/delay_line_flow_ctrl.sv
// delay_line_flow_ctrl: valid/ready flow control and flush sequencing around a delay line
module delay_line_flow_ctrl
  import delay_line_flow_ctrl_pkg::*;
#(
  parameter int N     = 9,
  parameter int DELAY = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [N-1:0]               idata,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [N-1:0]               odata,
  input  logic                       flush,
  output logic                       flush_done,
  output logic                       busy,
  output logic [occ_w(DELAY)-1:0]    occupancy
);
  localparam int OW = occ_w(DELAY);
  logic [DELAY-1:0] v_q, v_d;
  logic [OW-1:0] occ_q, occ_d;
  state_t state_q, state_d;
  logic ce, in_fire, out_fire;
  always_comb begin
    out_valid  = v_q[DELAY-1];
    ce         = en && (!out_valid || out_ready);
    in_ready   = ce && (state_q == RUN);
    in_fire    = in_valid && in_ready;
    out_fire   = out_valid && out_ready && en;
    v_d        = ce ? DELAY'({v_q, in_fire}) : v_q;
    occ_d      = occ_q + OW'(in_fire) - OW'(out_fire);
    state_d    = (state_q == RUN && en && flush)     ? FLUSH :
                 (state_q == FLUSH && occ_q == '0)   ? DONE  :
                 (state_q == DONE && en)             ? RUN   : state_q;
    flush_done = state_q == DONE;
    busy       = (occ_q != '0) || (state_q != RUN);
    occupancy  = occ_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      v_q     <= '0;
      occ_q   <= '0;
      state_q <= RUN;
    end else begin
      v_q     <= v_d;
      occ_q   <= occ_d;
      state_q <= state_d;
    end
  end
  delay_line #(.N(N), .DELAY(DELAY)) u_delay_line (
    .clk   (clk),
    .ce    (ce),
    .idata (idata),
    .odata (odata)
  );
endmodule

// File: tb/tb_delay_line_flow_ctrl.sv
// tb_delay_line_flow_ctrl: directed and randomized checks against a queue-based beat model
module tb_delay_line_flow_ctrl;
  localparam int N = 9;
  localparam int D = 2;
  localparam int OW = $clog2(D + 1);
  logic clk = 1'b0;
  logic rst, en, in_valid, out_ready, flush;
  logic in_ready, out_valid, flush_done, busy;
  logic [N-1:0] idata, odata;
  logic [OW-1:0] occupancy;
  typedef struct {
    logic [N-1:0] d;
    int           pos;
  } beat_t;
  beat_t q[$];
  int mst;
  int checks = 0;
  int errors = 0;
  logic e_ov, e_ce, e_ir, e_fd, e_busy;
  logic [N-1:0] e_od;
  int e_occ;
  always #5 clk = ~clk;
  delay_line_flow_ctrl #(.N(N), .DELAY(D)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .idata      (idata),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .odata      (odata),
    .flush      (flush),
    .flush_done (flush_done),
    .busy       (busy),
    .occupancy  (occupancy)
  );
  task automatic predict();
    e_ov   = (q.size() > 0) && (q[0].pos == D);
    e_ce   = en && (!e_ov || out_ready);
    e_ir   = e_ce && (mst == 0);
    e_od   = (q.size() > 0) ? q[0].d : '0;
    e_occ  = q.size();
    e_busy = (q.size() != 0) || (mst != 0);
    e_fd   = (mst == 2);
  endtask
  task automatic tick();
    int n;
    predict();
    n = q.size();
    if (rst) begin
      q.delete();
      mst = 0;
    end else begin
      if (e_ov && out_ready && en) void'(q.pop_front());
      if (e_ce) foreach (q[i]) q[i].pos = q[i].pos + 1;
      if (in_valid && e_ir) q.push_back('{d: idata, pos: 1});
      if (mst == 0 && en && flush) mst = 1;
      else if (mst == 1 && n == 0) mst = 2;
      else if (mst == 2 && en) mst = 0;
    end
    @(posedge clk);
    #1;
  endtask
  task automatic settle();
    rst = 0; en = 1; in_valid = 0; out_ready = 1; flush = 0;
    repeat (D + 4) tick();
  endtask
  task automatic test_reset();
    rst = 1; en = 1; in_valid = 0; out_ready = 0; flush = 0; idata = '0;
    tick();
    tick();
    rst = 0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    checks++; if (occupancy !== '0) begin errors++; $display("FAIL reset_occupancy got %0d exp 0", occupancy); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (flush_done !== 1'b0) begin errors++; $display("FAIL reset_flush_done got %b exp 0", flush_done); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
  endtask
  task automatic test_stream();
    int ove[6] = '{0, 0, 1, 1, 1, 0};
    int occe[6] = '{0, 1, 2, 2, 1, 0};
    for (int t = 0; t < 6; t++) begin
      in_valid = (t < 3); idata = N'(t + 1); out_ready = 1;
      #1;
      checks++; if (out_valid !== 1'(ove[t])) begin errors++; $display("FAIL stream_out_valid t%0d got %b exp %0d", t, out_valid, ove[t]); end
      checks++; if (occupancy !== OW'(occe[t])) begin errors++; $display("FAIL stream_occupancy t%0d got %0d exp %0d", t, occupancy, occe[t]); end
      if (ove[t] != 0) begin
        checks++; if (odata !== N'(t - 1)) begin errors++; $display("FAIL stream_odata t%0d got %h exp %h", t, odata, N'(t - 1)); end
      end
      tick();
    end
  endtask
  task automatic test_backpressure();
    logic [N-1:0] a, b;
    int got;
    a = N'($urandom); b = N'($urandom);
    out_ready = 0; in_valid = 1; idata = a;
    tick();
    idata = b;
    tick();
    idata = N'($urandom);
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready got %b exp 0", in_ready); end
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_out_valid got %b exp 1", out_valid); end
      checks++; if (odata !== a) begin errors++; $display("FAIL bp_odata_held got %h exp %h", odata, a); end
      checks++; if (occupancy !== OW'(2)) begin errors++; $display("FAIL bp_occupancy got %0d exp 2", occupancy); end
      tick();
    end
    in_valid = 0; out_ready = 1; got = 0;
    for (int c = 0; c < 8; c++) begin
      #1;
      if (out_valid) begin
        checks++; if (odata !== (got == 0 ? a : b)) begin errors++; $display("FAIL bp_order beat%0d got %h exp %h", got, odata, got == 0 ? a : b); end
        got++;
      end
      tick();
    end
    checks++; if (got != 2) begin errors++; $display("FAIL bp_count got %0d exp 2", got); end
    checks++; if (occupancy !== '0) begin errors++; $display("FAIL bp_final_occupancy got %0d exp 0", occupancy); end
  endtask
  task automatic test_bubble();
    int seen;
    out_ready = 0; in_valid = 1; idata = 9'h0AA;
    tick();
    in_valid = 0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bubble_early_valid got %b exp 0", out_valid); end
    tick();
    #1;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bubble_arrive_valid got %b exp 1", out_valid); end
    checks++; if (odata !== 9'h0AA) begin errors++; $display("FAIL bubble_arrive_odata got %h exp 0aa", odata); end
    checks++; if (occupancy !== OW'(1)) begin errors++; $display("FAIL bubble_occupancy got %0d exp 1", occupancy); end
    in_valid = 1; idata = 9'h055;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bubble_stall_in_ready got %b exp 0", in_ready); end
      checks++; if (odata !== 9'h0AA || out_valid !== 1'b1) begin errors++; $display("FAIL bubble_hold got %b/%h exp 1/0aa", out_valid, odata); end
      tick();
    end
    out_ready = 1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bubble_release_in_ready got %b exp 1", in_ready); end
    tick();
    in_valid = 0; seen = 0;
    for (int c = 0; c < 6; c++) begin
      #1;
      if (out_valid) begin
        checks++; if (odata !== 9'h055) begin errors++; $display("FAIL bubble_second_odata got %h exp 055", odata); end
        seen++;
      end
      tick();
    end
    checks++; if (seen != 1) begin errors++; $display("FAIL bubble_second_count got %0d exp 1", seen); end
  endtask
  task automatic test_flush_traffic();
    logic [N-1:0] a, b;
    int got, pulses;
    a = N'($urandom); b = N'($urandom);
    out_ready = 0; in_valid = 1; idata = a;
    tick();
    idata = b;
    tick();
    in_valid = 0; flush = 1;
    #1;
    checks++; if (occupancy !== OW'(2)) begin errors++; $display("FAIL flush_pre_occupancy got %0d exp 2", occupancy); end
    tick();
    flush = 0; in_valid = 1; idata = N'($urandom);
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_in_ready got %b exp 0", in_ready); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL flush_busy got %b exp 1", busy); end
    in_valid = 0; out_ready = 1; got = 0; pulses = 0;
    for (int c = 0; c < 12; c++) begin
      #1;
      if (out_valid) begin
        checks++; if (odata !== (got == 0 ? a : b)) begin errors++; $display("FAIL flush_drain beat%0d got %h exp %h", got, odata, got == 0 ? a : b); end
        got++;
      end
      if (flush_done) begin
        pulses++;
        checks++; if (occupancy !== '0) begin errors++; $display("FAIL flush_done_occupancy got %0d exp 0", occupancy); end
      end
      tick();
    end
    checks++; if (got != 2) begin errors++; $display("FAIL flush_drain_count got %0d exp 2", got); end
    checks++; if (pulses != 1) begin errors++; $display("FAIL flush_done_pulses got %0d exp 1", pulses); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_after_in_ready got %b exp 1", in_ready); end
  endtask
  task automatic test_flush_empty();
    in_valid = 0; out_ready = 1; flush = 1;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL fe_f_busy got %b exp 0", busy); end
    tick();
    flush = 0;
    #1;
    checks++; if (busy !== 1'b1 || flush_done !== 1'b0) begin errors++; $display("FAIL fe_f1 busy/done got %b/%b exp 1/0", busy, flush_done); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL fe_f1_in_ready got %b exp 0", in_ready); end
    tick();
    #1;
    checks++; if (busy !== 1'b1 || flush_done !== 1'b1) begin errors++; $display("FAIL fe_f2 busy/done got %b/%b exp 1/1", busy, flush_done); end
    tick();
    #1;
    checks++; if (busy !== 1'b0 || flush_done !== 1'b0) begin errors++; $display("FAIL fe_f3 busy/done got %b/%b exp 0/0", busy, flush_done); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL fe_f3_in_ready got %b exp 1", in_ready); end
  endtask
  task automatic test_enable();
    logic [N-1:0] a, b;
    int got;
    a = N'($urandom); b = N'($urandom);
    out_ready = 1; in_valid = 1; idata = a;
    tick();
    idata = b;
    tick();
    en = 0; idata = N'($urandom);
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL en_in_ready got %b exp 0", in_ready); end
      checks++; if (occupancy !== OW'(2)) begin errors++; $display("FAIL en_occupancy got %0d exp 2", occupancy); end
      checks++; if (out_valid !== 1'b1 || odata !== a) begin errors++; $display("FAIL en_hold got %b/%h exp 1/%h", out_valid, odata, a); end
      tick();
    end
    en = 1; in_valid = 0; got = 0;
    for (int c = 0; c < 6; c++) begin
      #1;
      if (out_valid) begin
        checks++; if (odata !== (got == 0 ? a : b)) begin errors++; $display("FAIL en_resume beat%0d got %h exp %h", got, odata, got == 0 ? a : b); end
        got++;
      end
      tick();
    end
    checks++; if (got != 2) begin errors++; $display("FAIL en_resume_count got %0d exp 2", got); end
  endtask
  task automatic test_reset_mid();
    out_ready = 0; in_valid = 1; idata = N'($urandom);
    tick();
    idata = N'($urandom);
    tick();
    in_valid = 0;
    #1;
    checks++; if (occupancy !== OW'(2)) begin errors++; $display("FAIL rmid_pre_occupancy got %0d exp 2", occupancy); end
    rst = 1;
    tick();
    rst = 0;
    #1;
    checks++; if (out_valid !== 1'b0 || occupancy !== '0) begin errors++; $display("FAIL rmid_state got %b/%0d exp 0/0", out_valid, occupancy); end
    checks++; if (busy !== 1'b0 || flush_done !== 1'b0) begin errors++; $display("FAIL rmid_busy_done got %b/%b exp 0/0", busy, flush_done); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rmid_in_ready got %b exp 1", in_ready); end
  endtask
  task automatic test_random();
    for (int c = 0; c < 500; c++) begin
      rst       = ($urandom_range(0, 99) == 0);
      en        = ($urandom_range(0, 9) != 0);
      in_valid  = ($urandom_range(0, 2) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 29) == 0);
      idata     = N'($urandom);
      #1;
      predict();
      checks++; if (out_valid !== e_ov) begin errors++; $display("FAIL rnd_out_valid c%0d got %b exp %b", c, out_valid, e_ov); end
      checks++; if (in_ready !== e_ir) begin errors++; $display("FAIL rnd_in_ready c%0d got %b exp %b", c, in_ready, e_ir); end
      checks++; if (occupancy !== OW'(e_occ)) begin errors++; $display("FAIL rnd_occupancy c%0d got %0d exp %0d", c, occupancy, e_occ); end
      checks++; if (busy !== e_busy) begin errors++; $display("FAIL rnd_busy c%0d got %b exp %b", c, busy, e_busy); end
      checks++; if (flush_done !== e_fd) begin errors++; $display("FAIL rnd_flush_done c%0d got %b exp %b", c, flush_done, e_fd); end
      if (e_ov) begin
        checks++; if (odata !== e_od) begin errors++; $display("FAIL rnd_odata c%0d got %h exp %h", c, odata, e_od); end
      end
      tick();
    end
    rst = 0;
  endtask
  initial begin
    q.delete();
    mst = 0;
    test_reset();
    test_stream();
    settle();
    test_backpressure();
    settle();
    test_bubble();
    settle();
    test_flush_traffic();
    settle();
    test_flush_empty();
    settle();
    test_enable();
    settle();
    test_reset_mid();
    settle();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
